// File: rtl/aes_out_sched_pkg.sv
// rtl/aes_out_sched_pkg.sv - shared AES constants and output scheduler state encodings
package aes_out_sched_pkg;

    // AES state geometry: Nb columns of WORD_S-bit words
    localparam int Nb     = 4;
    localparam int WORD_S = 32;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t SCHED_IDLE    = 2'd0;
    localparam sched_state_t SCHED_COLLECT = 2'd1;
    localparam sched_state_t SCHED_DONE    = 2'd2;

endpackage

// File: rtl/aes_out_sched_if.sv
// rtl/aes_out_sched_if.sv - write port bundle from the scheduler into the output FIFO
//
// Signals:
//   out_fifo_write_tvalid          master -> slave  write strobe
//   aes_controller_out_fifo_data   master -> slave  write data
//   out_fifo_write_tready          slave -> master  FIFO can accept
//   out_fifo_almost_full           slave -> master  FIFO almost full
interface aes_out_sched_if #(
    parameter int FIFO_DATA_WIDTH = 128
);
    logic                       out_fifo_write_tvalid;
    logic [FIFO_DATA_WIDTH-1:0] aes_controller_out_fifo_data;
    logic                       out_fifo_write_tready;
    logic                       out_fifo_almost_full;

    modport master (
        output out_fifo_write_tvalid,
        output aes_controller_out_fifo_data,
        input  out_fifo_write_tready,
        input  out_fifo_almost_full
    );

    modport slave (
        input  out_fifo_write_tvalid,
        input  aes_controller_out_fifo_data,
        output out_fifo_write_tready,
        output out_fifo_almost_full
    );
endinterface

// File: rtl/aes_out_sched_rr_turn_counter.sv
// rtl/aes_out_sched_rr_turn_counter.sv - modulo-MODULUS counter with enable and synchronous clear
//
// Ports:
//   clk     in   clock
//   resetn  in   synchronous active-low reset
//   clr     in   synchronous clear to 0 (wins over en)
//   en      in   advance by one, wrapping to 0 after MODULUS-1
//   count   out  current value
module rr_turn_counter #(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/aes_out_sched.sv
// rtl/aes_out_sched.sv - in-order round-robin collector of AES engine results into the output FIFO
//
// Ports:
//   m00_axis_aclk     in   clock
//   m00_axis_aresetn  in   synchronous active-low reset
//   pkt_start         in   new packet pulse; pkt_blk_cnt sampled with it
//   pkt_blk_cnt       in   blocks in the packet
//   eng_tvalid        in   per-engine result valid
//   eng_data          in   per-engine 128-bit results, engine i at [i*W +: W]
//   eng_tready        out  one-hot accept to the engine whose turn it is
//   out_fifo          if   master side of the output FIFO write port
//   axis_master_done  in   final stream beat sent
//   processing_done   out  all blocks of the packet written
//   busy              out  scheduler not idle
//   turn              out  current turn pointer
//
// Build option: AES_OUT_SCHED_THROTTLE_EN also withholds grant while the FIFO is almost full.
module aes_out_sched
    import aes_out_sched_pkg::*;
#(
    parameter int NUM_ENGINES     = 2,
    parameter int ENG_IDX_WIDTH   = 1,
    parameter int BLK_CNT_WIDTH   = 16,
    parameter int FIFO_DATA_WIDTH = 128
) (
    input  logic                                   m00_axis_aclk,
    input  logic                                   m00_axis_aresetn,
    input  logic                                   pkt_start,
    input  logic [BLK_CNT_WIDTH-1:0]               pkt_blk_cnt,
    input  logic [NUM_ENGINES-1:0]                 eng_tvalid,
    input  logic [NUM_ENGINES*FIFO_DATA_WIDTH-1:0] eng_data,
    output logic [NUM_ENGINES-1:0]                 eng_tready,
    aes_out_sched_if.master                        out_fifo,
    input  logic                                   axis_master_done,
    output logic                                   processing_done,
    output logic                                   busy,
    output logic [ENG_IDX_WIDTH-1:0]               turn
);
    sched_state_t             state;
    logic [BLK_CNT_WIDTH-1:0] remaining;
    logic                     fifo_ok;
    logic                     grant;
    logic                     start_pkt;

`ifdef AES_OUT_SCHED_THROTTLE_EN
    assign fifo_ok = out_fifo.out_fifo_write_tready && !out_fifo.out_fifo_almost_full;
`else
    logic unused_almost_full;
    assign unused_almost_full = out_fifo.out_fifo_almost_full;
    assign fifo_ok = out_fifo.out_fifo_write_tready;
`endif

    // Only the engine whose turn it is can be granted; others wait their rotation.
    assign grant     = (state == SCHED_COLLECT) && eng_tvalid[turn] && fifo_ok;
    assign start_pkt = (state == SCHED_IDLE) && pkt_start && (pkt_blk_cnt != '0);

    assign eng_tready                            = grant ? (NUM_ENGINES'(1) << turn) : '0;
    assign out_fifo.out_fifo_write_tvalid        = grant;
    assign out_fifo.aes_controller_out_fifo_data =
        eng_data[int'(turn)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
    assign busy = (state != SCHED_IDLE);

    rr_turn_counter #(
        .MODULUS (NUM_ENGINES),
        .WIDTH   (ENG_IDX_WIDTH)
    ) u_turn (
        .clk    (m00_axis_aclk),
        .resetn (m00_axis_aresetn),
        .clr    (start_pkt),
        .en     (grant),
        .count  (turn)
    );

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state           <= SCHED_IDLE;
            remaining       <= '0;
            processing_done <= 1'b0;
        end else begin
            case (state)
                SCHED_IDLE: begin
                    if (pkt_start) begin
                        if (pkt_blk_cnt != '0) begin
                            remaining <= pkt_blk_cnt;
                            state     <= SCHED_COLLECT;
                        end else begin
                            state           <= SCHED_DONE;
                            processing_done <= 1'b1;
                        end
                    end
                end
                SCHED_COLLECT: begin
                    if (grant) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == BLK_CNT_WIDTH'(1)) begin
                            state           <= SCHED_DONE;
                            processing_done <= 1'b1;
                        end
                    end
                end
                SCHED_DONE: begin
                    if (axis_master_done) begin
                        state           <= SCHED_IDLE;
                        processing_done <= 1'b0;
                    end
                end
                default: begin
                    state           <= SCHED_IDLE;
                    processing_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_out_sched.sv
// tb/tb_aes_out_sched.sv - randomized self-checking bench for aes_out_sched against a packet-level model
module tb_aes_out_sched;
    localparam int N  = 2;
    localparam int IW = 1;
    localparam int BW = 16;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            resetn;
    logic            pkt_start;
    logic [BW-1:0]   pkt_blk_cnt;
    logic [N-1:0]    eng_tvalid;
    logic [N*DW-1:0] eng_data;
    logic [N-1:0]    eng_tready;
    logic            axis_master_done;
    logic            processing_done;
    logic            busy;
    logic [IW-1:0]   turn;

    aes_out_sched_if #(.FIFO_DATA_WIDTH(DW)) fif ();

    aes_out_sched #(
        .NUM_ENGINES     (N),
        .ENG_IDX_WIDTH   (IW),
        .BLK_CNT_WIDTH   (BW),
        .FIFO_DATA_WIDTH (DW)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (resetn),
        .pkt_start        (pkt_start),
        .pkt_blk_cnt      (pkt_blk_cnt),
        .eng_tvalid       (eng_tvalid),
        .eng_data         (eng_data),
        .eng_tready       (eng_tready),
        .out_fifo         (fif.master),
        .axis_master_done (axis_master_done),
        .processing_done  (processing_done),
        .busy             (busy),
        .turn             (turn)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet-level model: blocks still owed, blocks already written, and whether
    // the packet is finished and waiting on the stream master.
    int  m_left;
    int  m_written;
    bit  m_wait;
    int  grants_seen;

    function automatic bit model_grant();
        int idx;
        bit ok;
        idx = m_written % N;
        ok  = fif.out_fifo_write_tready;
`ifdef AES_OUT_SCHED_THROTTLE_EN
        ok  = ok && !fif.out_fifo_almost_full;
`endif
        return (m_left > 0) && eng_tvalid[idx] && ok;
    endfunction

    task automatic check_outputs(input string pfx);
        bit               g;
        int               idx;
        logic [N-1:0]     exp_rdy;
        logic [DW-1:0]    exp_data;
        g        = model_grant();
        idx      = m_written % N;
        exp_rdy  = '0;
        if (g) exp_rdy[idx] = 1'b1;
        exp_data = eng_data[idx*DW +: DW];
        check({pfx, ".eng_tready"}, DW'(eng_tready), DW'(exp_rdy));
        check({pfx, ".wvalid"}, DW'(fif.out_fifo_write_tvalid), DW'(g));
        if (g) check({pfx, ".wdata"}, fif.aes_controller_out_fifo_data, exp_data);
        check({pfx, ".busy"}, DW'(busy), DW'((m_left > 0) || m_wait));
        check({pfx, ".processing_done"}, DW'(processing_done), DW'(m_wait));
        check({pfx, ".turn"}, DW'(turn), DW'(idx));
    endtask

    task automatic model_step();
        bit g;
        g = model_grant();
        if (!resetn) begin
            m_left = 0; m_wait = 0; m_written = 0;
        end else if (g) begin
            grants_seen++;
            m_written++;
            m_left--;
            if (m_left == 0) m_wait = 1;
        end else if (m_left == 0 && !m_wait && pkt_start) begin
            if (pkt_blk_cnt == 0) m_wait = 1;
            else begin
                m_left    = int'(pkt_blk_cnt);
                m_written = 0;
            end
        end else if (m_wait && axis_master_done) begin
            m_wait = 0;
        end
    endtask

    task automatic drive_random();
        resetn                   = ($urandom_range(0, 79) != 0);
        pkt_start                = ($urandom_range(0, 3) == 0);
        pkt_blk_cnt              = BW'($urandom_range(0, 6));
        eng_tvalid               = N'($urandom);
        for (int e = 0; e < N; e++)
            eng_data[e*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        fif.out_fifo_write_tready = ($urandom_range(0, 3) != 0);
        fif.out_fifo_almost_full  = ($urandom_range(0, 3) == 0);
        axis_master_done          = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        resetn = 1'b0; pkt_start = 1'b0; pkt_blk_cnt = '0; eng_tvalid = '0; eng_data = '0;
        fif.out_fifo_write_tready = 1'b1; fif.out_fifo_almost_full = 1'b0; axis_master_done = 1'b0;
        m_left = 0; m_written = 0; m_wait = 0; grants_seen = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", DW'(busy), '0);
        check("reset.processing_done", DW'(processing_done), '0);
        check("reset.turn", DW'(turn), '0);
        check("reset.eng_tready", DW'(eng_tready), '0);
        check("reset.wvalid", DW'(fif.out_fifo_write_tvalid), '0);

        // Directed: 4-block packet, both engines valid, FIFO ready -> 0,1,0,1 back to back.
        resetn = 1'b1; pkt_start = 1'b1; pkt_blk_cnt = 16'd4;
        @(posedge clk); model_step();
        @(negedge clk);
        pkt_start = 1'b0; eng_tvalid = '1;
        for (int b = 0; b < 4; b++) begin
            for (int e = 0; e < N; e++)
                eng_data[e*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check_outputs("dir");
            @(posedge clk); model_step();
            @(negedge clk);
        end
        eng_tvalid = '0;
        #1;
        check("dir.done_after_last", DW'(processing_done), DW'(1));
        axis_master_done = 1'b1;
        @(posedge clk); model_step();
        @(negedge clk);
        axis_master_done = 1'b0;
        #1;
        check("dir.done_cleared", DW'(processing_done), '0);
        check("dir.busy_cleared", DW'(busy), '0);

        // Randomized run against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_outputs("rnd");
            @(posedge clk);
            model_step();
        end

        @(negedge clk);
        if (grants_seen < 200) check("rnd.grant_activity", DW'(grants_seen), DW'(200));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
